// File: rtl/sram_controller_pkg.sv
// Shared types and constants for the asynchronous SRAM initiator.
// Package name is sram_pkg; imported by sram_controller_if and sram_controller.
package sram_pkg;

    localparam int unsigned SRAM_READ_WAIT  = 2;
    localparam int unsigned SRAM_WRITE_WAIT = 1;
    localparam int unsigned SRAM_ADDR_W     = 20;
    localparam int unsigned SRAM_DATA_W     = 16;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        DONE
    } sram_state_t;

    // Pin levels a state presents: {ce_n, oe_n, we_n, dq_drive}.
    // Kept in one place so OE/WE and OE/DQ exclusivity is visible at a glance.
    function automatic logic [3:0] strobe_levels(input sram_state_t s);
        logic [3:0] lvl;
        case (s)
            RD_WAIT:  lvl = 4'b0010;
            WR_SETUP: lvl = 4'b0111;
            WR_PULSE: lvl = 4'b0101;
            WR_HOLD:  lvl = 4'b1111;
            default:  lvl = 4'b1110;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/sram_controller_if.sv
// CPU-side request/response bundle for sram_controller.
// master = requester (memory-access stage), slave = controller.
interface sram_controller_if;
    import sram_pkg::*;

    logic                   ReqValid;
    logic                   ReqReady;
    logic                   ReqWrite;
    logic [SRAM_ADDR_W-1:0] ReqAddr;
    logic [SRAM_DATA_W-1:0] ReqWData;
    logic [1:0]             ReqBE;
    logic [SRAM_DATA_W-1:0] RData;
    logic                   Done;

    modport master (
        output ReqValid, ReqWrite, ReqAddr, ReqWData, ReqBE,
        input  ReqReady, RData, Done
    );

    modport slave (
        input  ReqValid, ReqWrite, ReqAddr, ReqWData, ReqBE,
        output ReqReady, RData, Done
    );

endinterface

// File: rtl/sram_controller.sv
// Asynchronous SRAM initiator: one access in flight, registered active-low
// strobes, tri-stated DQ. Optional per-byte lanes under SRAM_BYTE_LANES_EN.
//
// state    | meaning
// IDLE     | ready for a request, strobes high, DQ released
// RD_WAIT  | CE/OE low for ReadWait cycles, DQ captured on the last edge
// WR_SETUP | CE low, DQ driven, WE still high
// WR_PULSE | WE low for WriteWait cycles
// WR_HOLD  | CE/WE high, DQ still driven for hold time
// DONE     | Done pulse, strobes high, not ready
module sram_controller
    import sram_pkg::*;
#(
    parameter int unsigned ReadWait  = SRAM_READ_WAIT,
    parameter int unsigned WriteWait = SRAM_WRITE_WAIT
) (
    input  logic                   Clk,
    input  logic                   Reset,
    sram_controller_if.slave       req,
    output logic                   CE,
    output logic                   OE,
    output logic                   WE,
    output logic                   LB,
    output logic                   UB,
    output logic [SRAM_ADDR_W-1:0] ADDR,
    inout  wire  [SRAM_DATA_W-1:0] DQ
);

    // Counters run load..0, so the load value is one less than the wait.
    localparam logic [3:0] RD_LOAD = 4'(ReadWait - 1);
    localparam logic [3:0] WR_LOAD = 4'(WriteWait - 1);

    sram_state_t            state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [SRAM_ADDR_W-1:0] addr_q;
    logic [SRAM_DATA_W-1:0] wdata_q;
    logic [SRAM_DATA_W-1:0] rdata_q;
    logic                   ce_q, oe_q, we_q, lb_q, ub_q, dq_oe_q;
    logic                   accept;
    logic                   noop;
    logic [3:0]             lvl_d;
    logic [SRAM_DATA_W-1:0] lane_mask;
    logic [1:0]             be_next;

`ifdef SRAM_BYTE_LANES_EN
    logic [1:0] be_q;
    assign noop      = (req.ReqBE == 2'b00);
    assign be_next   = accept ? req.ReqBE : be_q;
    assign lane_mask = {{8{be_q[1]}}, {8{be_q[0]}}};
`else
    logic [1:0] unused_be;
    assign unused_be = req.ReqBE;
    assign noop      = 1'b0;
    assign be_next   = 2'b11;
    assign lane_mask = '1;
`endif

    assign accept       = req.ReqValid && (state_q == IDLE);
    assign lvl_d        = strobe_levels(state_d);
    assign req.ReqReady = (state_q == IDLE);
    assign req.Done     = (state_q == DONE);
    assign req.RData    = rdata_q;
    assign CE           = ce_q;
    assign OE           = oe_q;
    assign WE           = we_q;
    assign LB           = lb_q;
    assign UB           = ub_q;
    assign ADDR         = addr_q;
    assign DQ           = dq_oe_q ? wdata_q : 'z;

    // Next-state and wait-counter sequencing.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (noop) begin
                        state_d = DONE;
                    end else if (req.ReqWrite) begin
                        state_d = WR_SETUP;
                    end else begin
                        state_d = RD_WAIT;
                        cnt_d   = RD_LOAD;
                    end
                end
            end
            RD_WAIT: begin
                if (cnt_q == 4'd0) state_d = DONE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            WR_SETUP: begin
                state_d = WR_PULSE;
                cnt_d   = WR_LOAD;
            end
            WR_PULSE: begin
                if (cnt_q == 4'd0) state_d = WR_HOLD;
                else               cnt_d   = cnt_q - 4'd1;
            end
            WR_HOLD: state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, request latch, registered pin levels and read capture.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ce_q    <= 1'b1;
            oe_q    <= 1'b1;
            we_q    <= 1'b1;
            lb_q    <= 1'b1;
            ub_q    <= 1'b1;
            dq_oe_q <= 1'b0;
`ifdef SRAM_BYTE_LANES_EN
            be_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                addr_q  <= req.ReqAddr;
                wdata_q <= req.ReqWData;
`ifdef SRAM_BYTE_LANES_EN
                be_q    <= req.ReqBE;
`endif
            end
            ce_q    <= lvl_d[3];
            oe_q    <= lvl_d[2];
            we_q    <= lvl_d[1];
            dq_oe_q <= lvl_d[0];
            lb_q    <= lvl_d[3] | ~be_next[0];
            ub_q    <= lvl_d[3] | ~be_next[1];
            if (state_q == RD_WAIT && cnt_q == 4'd0) begin
                rdata_q <= DQ & lane_mask;
            end
        end
    end

endmodule
